// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch and data ports share one memory
// controller with round-robin priority. Optional macro: MEM_ARB_IBUF_EN.
module mem_arbiter #(
   parameter bit         D_FIRST      = 1'b1,
   parameter logic [2:0] IFETCH_BYTES = 3'd4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic [31:0] i_data,
   output logic        i_done,
   input  logic        d_req,
   input  logic        d_is_write,
   input  logic [2:0]  d_num_bytes,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_done,
   output logic        m_start_request,
   output logic        m_is_write,
   output logic        m_is_data_fetch,
   output logic [2:0]  m_num_bytes,
   output logic [31:0] m_target_address,
   output logic [31:0] m_write_value,
   input  logic [31:0] m_fetched_data,
   input  logic        m_request_done,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE,
      GRANT_I,
      GRANT_D,
      WAIT_DROP
   } state_t;

   state_t      state_q;
   logic        prio_d_q;
   logic        owner_d_q;
   logic        ack_q;
   logic        m_start_q;
   logic        m_is_write_q;
   logic        m_is_data_q;
   logic [2:0]  m_num_bytes_q;
   logic [31:0] m_addr_q;
   logic [31:0] m_wval_q;
   logic [31:0] i_data_q;
   logic [31:0] d_rdata_q;
   logic        grant_i;
   logic        grant_d;
   logic        ib_hit;

`ifdef MEM_ARB_IBUF_EN
   logic        ib_valid_q;
   logic [31:0] ib_tag_q;
   logic [31:0] ib_word_q;

   assign ib_hit = ib_valid_q && (i_addr == ib_tag_q);

   // Instruction buffer: refilled by each fetch, invalidated by any store
   always_ff @(posedge clk) begin
      if (rst) begin
         ib_valid_q <= 1'b0;
         ib_tag_q   <= 32'd0;
         ib_word_q  <= 32'd0;
      end else if (m_request_done && state_q == GRANT_I) begin
         ib_valid_q <= 1'b1;
         ib_tag_q   <= m_addr_q;
         ib_word_q  <= m_fetched_data;
      end else if (m_request_done && state_q == GRANT_D && m_is_write_q) begin
         ib_valid_q <= 1'b0;
      end
   end
`else
   assign ib_hit = 1'b0;
`endif

   // Winner of an IDLE arbitration round; ties go to the priority holder
   always_comb begin
      grant_d = d_req && (!i_req || prio_d_q);
      grant_i = i_req && !grant_d;
   end

   // Arbiter FSM with registered memory-side controls
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         prio_d_q      <= D_FIRST;
         owner_d_q     <= 1'b0;
         ack_q         <= 1'b0;
         m_start_q     <= 1'b0;
         m_is_write_q  <= 1'b0;
         m_is_data_q   <= 1'b0;
         m_num_bytes_q <= 3'd0;
         m_addr_q      <= 32'd0;
         m_wval_q      <= 32'd0;
         i_data_q      <= 32'd0;
         d_rdata_q     <= 32'd0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (grant_i && ib_hit) begin
`ifdef MEM_ARB_IBUF_EN
                  i_data_q  <= ib_word_q;
`endif
                  owner_d_q <= 1'b0;
                  ack_q     <= 1'b1;
                  state_q   <= WAIT_DROP;
               end else if (grant_i) begin
                  state_q       <= GRANT_I;
                  owner_d_q     <= 1'b0;
                  prio_d_q      <= 1'b1;
                  m_start_q     <= 1'b1;
                  m_is_write_q  <= 1'b0;
                  m_is_data_q   <= 1'b0;
                  m_num_bytes_q <= IFETCH_BYTES;
                  m_addr_q      <= i_addr;
                  m_wval_q      <= 32'd0;
               end else if (grant_d) begin
                  state_q       <= GRANT_D;
                  owner_d_q     <= 1'b1;
                  prio_d_q      <= 1'b0;
                  m_start_q     <= 1'b1;
                  m_is_write_q  <= d_is_write;
                  m_is_data_q   <= 1'b1;
                  m_num_bytes_q <= d_num_bytes;
                  m_addr_q      <= d_addr;
                  m_wval_q      <= d_wdata;
               end
            end
            GRANT_I: begin
               if (m_request_done) begin
                  m_start_q <= 1'b0;
                  i_data_q  <= m_fetched_data;
                  ack_q     <= i_req;
                  state_q   <= WAIT_DROP;
               end
            end
            GRANT_D: begin
               if (m_request_done) begin
                  m_start_q <= 1'b0;
                  if (!m_is_write_q) begin
                     d_rdata_q <= m_fetched_data;
                  end
                  ack_q   <= d_req;
                  state_q <= WAIT_DROP;
               end
            end
            WAIT_DROP: begin
               if (owner_d_q ? !d_req : !i_req) begin
                  ack_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign m_start_request  = m_start_q;
   assign m_is_write       = m_is_write_q;
   assign m_is_data_fetch  = m_is_data_q;
   assign m_num_bytes      = m_num_bytes_q;
   assign m_target_address = m_addr_q;
   assign m_write_value    = m_wval_q;
   assign i_data           = i_data_q;
   assign d_rdata          = d_rdata_q;
   assign busy             = (state_q != IDLE);
   assign i_done = (state_q == WAIT_DROP) && ack_q && !owner_d_q && i_req;
   assign d_done = (state_q == WAIT_DROP) && ack_q && owner_d_q && d_req;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: D_FIRST, 1, priority holder after reset (1 = data port wins first tie, 0 = instruction port).
REQ-002 Parameter: IFETCH_BYTES, 3'd4, num_bytes driven for every instruction fetch.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  system clock, all state on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 i_req  in  1  instruction fetch request, level, held until i_done.
REQ-007 i_addr  in  32  instruction fetch address.
REQ-008 i_data  out  32  fetched instruction word.
REQ-009 i_done  out  1  instruction fetch complete.
REQ-010 d_req  in  1  data request, level, held until d_done.
REQ-011 d_is_write  in  1  1 = store, 0 = load.
REQ-012 d_num_bytes  in  3  access size in bytes (1, 2, 4).
REQ-013 d_addr  in  32  data address.
REQ-014 d_wdata  in  32  store data.
REQ-015 d_rdata  out  32  load data.
REQ-016 d_done  out  1  data access complete.
REQ-017 m_start_request, m_is_write, m_is_data_fetch  out  1 each  to memory controller.
REQ-018 m_num_bytes  out  3; m_target_address, m_write_value  out  32 each  to memory controller.
REQ-019 m_fetched_data  in  32; m_request_done  in  1  from memory controller.
REQ-020 busy  out  1  high in any state other than IDLE.

Function
REQ-021 FSM states: IDLE, GRANT_I, GRANT_D, WAIT_DROP.
REQ-022 IDLE: only i_req -> GRANT_I; only d_req -> GRANT_D; both -> port holding priority; none -> stay.
REQ-023 Priority is round-robin: after each grant, priority passes to the other port.
REQ-024 Request sampled in IDLE at cycle N -> m_start_request high from cycle N+1.
REQ-025 On grant, address, write data, size and is_write are latched into registers; m_* outputs driven only from these registers, stable for the whole grant.
REQ-026 GRANT_I drives m_is_write=0, m_is_data_fetch=0, m_num_bytes=IFETCH_BYTES; GRANT_D drives m_is_data_fetch=1 and the latched d_* controls.
REQ-027 In GRANT_x, m_start_request=1 until the cycle m_request_done=1; m_fetched_data is then captured into i_data or d_rdata (d_rdata not updated on stores) -> WAIT_DROP.
REQ-028 WAIT_DROP: m_start_request=0; x_done=1 while x_req=1; exit to IDLE on the first cycle x_req=0; minimum one cycle, so m_start_request is low at least one cycle between transactions.
REQ-029 x_req dropped during GRANT_x: transaction still completes; x_done never asserts; WAIT_DROP lasts one cycle.
REQ-030 The losing requester's request is held pending; at most one transaction is outstanding at any time.
REQ-031 i_data and d_rdata hold their values until the next capture.

Reset
REQ-032 rst=1 at any clock edge, including mid-transaction: state=IDLE, priority=D_FIRST, all m_* outputs, i_done, d_done and busy = 0; i_data and d_rdata = 0.
REQ-033 A transaction aborted by reset is not resumed; the requester must reissue it.

Configuration
REQ-034 Macro MEM_ARB_IBUF_EN defined: single-entry instruction buffer (valid bit, 32-bit tag, 32-bit word), filled on every completed instruction fetch.
REQ-035 With MEM_ARB_IBUF_EN: i_req in IDLE with valid=1 and i_addr==tag -> straight to WAIT_DROP with i_data=buffer and i_done next cycle; no memory access; priority unchanged.
REQ-036 With MEM_ARB_IBUF_EN: any completed store clears valid; reset clears valid.
REQ-037 Without MEM_ARB_IBUF_EN: no buffer logic; every instruction fetch goes to memory.

Verification
REQ-038 Instruction fetch i_addr=0x100, memory returns 0x00500093 after 10 cycles -> m_num_bytes=4, m_is_data_fetch=0, i_data=0x00500093, i_done high until i_req drops.
REQ-039 i_req and d_req both rise in the same cycle after reset with D_FIRST=1 -> data granted first, instruction second; repeat both -> data granted again (alternation holds).
REQ-040 Store d_addr=0x2000, d_wdata=0xDEADBEEF, d_num_bytes=1 -> m_is_write=1, m_write_value=0xDEADBEEF, d_rdata unchanged.
REQ-041 rst asserted mid GRANT_D -> next cycle m_start_request=0, busy=0, d_done=0; pending i_req is then served normally.
REQ-042 With MEM_ARB_IBUF_EN: fetch 0x100 twice -> second fetch completes with no m_start_request; a store in between -> second fetch goes to memory.
